// File: rtl/load_store_unit.sv
// RV32I load/store unit: aligns, masks and extends CPU accesses onto a word-wide memory port.
// Latency: one IDLE cycle + ACCESS until mem_ready (bounded by TIMEOUT) + one RESP/ERR cycle; stall holds the CPU meanwhile.
module load_store_unit #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             stall,
  output logic [WIDTH-1:0] load_data,
  output logic             done,
  output logic             err,
  output logic             mem_en,
  output logic             mem_we,
  output logic [3:0]       mem_be,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ready
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;
  localparam logic [1:0] S_ERR    = 2'd3;
  localparam logic [7:0] TO_CNT   = 8'(TIMEOUT);

  logic [1:0]       state;
  logic [7:0]       cnt;
  logic             lat_we;
  logic [2:0]       lat_f3;
  logic [1:0]       lat_off;

  logic             legal;
  logic             misal;
  logic [3:0]       be_n;
  logic [WIDTH-1:0] wdata_n;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;
  logic [WIDTH-1:0] ld_ext;

  // Request decode works straight off the CPU inputs so the memory port is ready on ACCESS entry.
  always_comb begin
    legal   = 1'b0;
    misal   = 1'b0;
    be_n    = 4'b1111;
    wdata_n = req_wdata;
    if (req_we) legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    else        legal = (req_funct3 != 3'b011) && (req_funct3 != 3'b110) && (req_funct3 != 3'b111);
    case (req_funct3[1:0])
      2'b00: begin
        be_n    = 4'b0001 << req_addr[1:0];
        wdata_n = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        misal   = req_addr[0];
        be_n    = 4'b0011 << req_addr[1:0];
        wdata_n = {2{req_wdata[15:0]}};
      end
      default: misal = (req_addr[1:0] != 2'b00);
    endcase
  end

  always_comb begin
    rd_byte = mem_rdata[{lat_off, 3'b000} +: 8];
    rd_half = mem_rdata[{lat_off[1], 4'b0000} +: 16];
    case (lat_f3)
      3'b000:  ld_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  ld_ext = {{16{rd_half[15]}}, rd_half};
      3'b100:  ld_ext = {24'd0, rd_byte};
      3'b101:  ld_ext = {16'd0, rd_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  assign stall = ((state == S_IDLE) && req_valid) || (state == S_ACCESS);
  assign done  = (state == S_RESP);
  assign err   = (state == S_ERR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 8'd0;
      lat_we    <= 1'b0;
      lat_f3    <= 3'b000;
      lat_off   <= 2'b00;
      load_data <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'b0000;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            lat_we  <= req_we;
            lat_f3  <= req_funct3;
            lat_off <= req_addr[1:0];
            if (legal && !misal) begin
              state     <= S_ACCESS;
              cnt       <= 8'd1;
              mem_en    <= 1'b1;
              mem_we    <= req_we;
              mem_be    <= be_n;
              mem_addr  <= {req_addr[WIDTH-1:2], 2'b00};
              mem_wdata <= wdata_n;
            end else begin
              state <= S_ERR;
            end
          end
        end
        S_ACCESS: begin
          // A ready on the final allowed cycle still completes the access.
          if (mem_ready) begin
            state  <= S_RESP;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (!lat_we) load_data <= ld_ext;
          end else if (cnt >= TO_CNT) begin
            state  <= S_ERR;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus random traffic checked against a byte-lane model.
module tb_load_store_unit;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic [31:0] load_data;
  logic        done;
  logic        err;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  load_store_unit #(.WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .load_data(load_data), .done(done), .err(err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] exp_ld = 32'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference model: plain arithmetic over access size and byte offset.
  function automatic int acc_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit m_ok(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    bit legal;
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd5 && f3 != 3'd3);
    return legal && ((addr % acc_size(f3)) == 0);
  endfunction

  function automatic logic [31:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
    int sz = acc_size(f3);
    return ((32'd1 << sz) - 32'd1) << (addr % 4);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    int sz = acc_size(f3);
    if (sz == 1) return (wd & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rd);
    int sz = acc_size(f3);
    logic [31:0] v = rd >> (8 * (addr % 4));
    if (sz == 1) begin
      v = v & 32'hFF;
      if (f3[2] == 1'b0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2) begin
      v = v & 32'hFFFF;
      if (f3[2] == 1'b0 && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  // One request from IDLE; ready_at = ACCESS cycle on which mem_ready is given (0 = never).
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd, input int ready_at,
                         output int n_access);
    bit finished = 0;
    int k = 0;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    mem_rdata = rd; mem_ready = 1'($urandom_range(0, 1));
    #1;
    check("stall_req", 32'(stall), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    mem_ready = 1'b0;
    if (!m_ok(we, f3, addr)) begin
      check("err_pulse", 32'(err), 32'd1);
      check("err_no_mem_en", 32'(mem_en), 32'd0);
      check("err_stall", 32'(stall), 32'd0);
      check("err_ld_hold", load_data, exp_ld);
      n_access = 0;
    end else begin
      while (!finished && k < TIMEOUT + 1) begin
        k++;
        check("acc_mem_en", 32'(mem_en), 32'd1);
        check("acc_stall", 32'(stall), 32'd1);
        check("acc_mem_we", 32'(mem_we), 32'(we));
        check("acc_mem_be", 32'(mem_be), m_be(f3, addr));
        check("acc_mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
        if (we) check("acc_mem_wdata", mem_wdata, m_wdata(f3, wd));
        mem_ready = (k == ready_at);
        @(negedge clk);
        mem_ready = 1'b0;
        if (k == ready_at) begin
          finished = 1;
          if (!we) exp_ld = m_load(f3, addr, rd);
          check("resp_done", 32'(done), 32'd1);
          check("resp_no_err", 32'(err), 32'd0);
          check("resp_mem_en", 32'(mem_en), 32'd0);
          check("resp_stall", 32'(stall), 32'd0);
          check("resp_load_data", load_data, exp_ld);
        end else if (k == TIMEOUT) begin
          finished = 1;
          check("to_err", 32'(err), 32'd1);
          check("to_no_done", 32'(done), 32'd0);
          check("to_mem_en", 32'(mem_en), 32'd0);
          check("to_ld_hold", load_data, exp_ld);
        end
      end
      if (!finished) check("txn_bound", 32'd0, 32'd1);
      n_access = k;
    end
    @(negedge clk);
    check("idle_done", 32'(done), 32'd0);
    check("idle_err", 32'(err), 32'd0);
    check("idle_mem_en", 32'(mem_en), 32'd0);
  endtask

  initial begin
    int na;
    logic [31:0] a;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'd0; req_wdata = 32'd0; mem_rdata = 32'd0; mem_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_be", 32'(mem_be), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_txn(1'b0, 3'b010, 32'h0000_0104, 32'd0, 32'hDEAD_BEEF, 2, na);
    check("lw_access_cycles", 32'(na), 32'd2);
    check("lw_value", load_data, 32'hDEAD_BEEF);
    run_txn(1'b0, 3'b000, 32'h0000_0107, 32'd0, 32'h80FF_1234, 1, na);
    check("lb_value", load_data, 32'hFFFF_FF80);
    run_txn(1'b0, 3'b100, 32'h0000_0107, 32'd0, 32'h80FF_1234, 3, na);
    check("lbu_value", load_data, 32'h0000_0080);
    run_txn(1'b0, 3'b101, 32'h0000_0102, 32'd0, 32'h80FF_1234, 1, na);
    check("lhu_value", load_data, 32'h0000_80FF);
    run_txn(1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h5555_5555, 2, na);
    check("sh_ld_hold", load_data, 32'h0000_80FF);
    run_txn(1'b0, 3'b010, 32'h0000_0101, 32'd0, 32'd0, 1, na);
    check("lw_misal_no_access", 32'(na), 32'd0);
    run_txn(1'b0, 3'b011, 32'h0000_0100, 32'd0, 32'd0, 1, na);
    run_txn(1'b0, 3'b010, 32'h0000_0300, 32'd0, 32'h1111_2222, 0, na);
    check("timeout_cycles", 32'(na), 32'(TIMEOUT));
    run_txn(1'b0, 3'b010, 32'h0000_0300, 32'd0, 32'h1111_2222, TIMEOUT, na);
    check("ready_last_cycle", load_data, 32'h1111_2222);

    // Reset in the middle of an access.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    check("mid_acc3_mem_en", 32'(mem_en), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_ld = 32'd0;
    check("midrst_mem_en", 32'(mem_en), 32'd0);
    check("midrst_load_data", load_data, 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    check("midrst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    check("midrst_after_done", 32'(done), 32'd0);
    check("midrst_after_err", 32'(err), 32'd0);

    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, $urandom,
              $urandom_range(0, TIMEOUT + 2), na);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data/address width (only 32 supported).
REQ-002 SHALL have parameter TIMEOUT, default 15, max ACCESS cycles waited for mem_ready (range 1..255).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req_valid  input  1  CPU load/store request present.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_funct3  input  3  RV32I width/sign code from instruction[14:12].
REQ-008 SHALL have port req_addr  input  WIDTH  byte address from ALU.
REQ-009 SHALL have port req_wdata  input  WIDTH  store data (rs2).
REQ-010 SHALL have port stall  output  1  CPU hold PC/regfile write.
REQ-011 SHALL have port load_data  output  WIDTH  extended load result.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port err  output  1  one-cycle misalign/illegal/timeout pulse.
REQ-014 SHALL have port mem_en  output  1  memory access request.
REQ-015 SHALL have port mem_we  output  1  memory write.
REQ-016 SHALL have port mem_be  output  4  byte enables.
REQ-017 SHALL have port mem_addr  output  WIDTH  word-aligned address.
REQ-018 SHALL have port mem_wdata  output  WIDTH  lane-aligned store data.
REQ-019 SHALL have port mem_rdata  input  WIDTH  memory read word.
REQ-020 SHALL have port mem_ready  input  1  memory accepts/completes access this cycle.

Function
REQ-021 SHALL implement FSM states IDLE, ACCESS, RESP, ERR.
REQ-022 IDLE: when req_valid=1, SHALL latch req_we/funct3/addr/wdata; legal and aligned -> ACCESS; else -> ERR.
REQ-023 Legal funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW; all others illegal.
REQ-024 Misaligned: halfword with addr[0]=1, word with addr[1:0]!=00; byte never misaligned.
REQ-025 stall SHALL equal (state==IDLE && req_valid) || state==ACCESS (combinational); low in RESP and ERR.
REQ-026 ACCESS: mem_en=1, mem_we=latched req_we, mem_addr={addr[31:2],2'b00}, outputs held stable until exit.
REQ-027 mem_be: word 1111; half 0011<<addr[1:0]; byte 0001<<addr[1:0]; loads use same mask.
REQ-028 mem_wdata: SB = byte replicated x4; SH = halfword replicated x2; SW = unchanged.
REQ-029 ACCESS with mem_ready=1 -> RESP; for loads, load_data SHALL register the selected lane, sign-extended (LB/LH) or zero-extended (LBU/LHU) at that edge.
REQ-030 ACCESS cycle counter SHALL count from 1 on entry; if count reaches TIMEOUT with mem_ready=0 -> ERR, mem_en deasserted next cycle.
REQ-031 mem_ready on the TIMEOUT-th cycle SHALL win over timeout (-> RESP).
REQ-032 RESP: done=1 one cycle, -> IDLE; req_valid ignored in RESP.
REQ-033 ERR: err=1 one cycle, no memory access performed, load_data unchanged, -> IDLE.
REQ-034 load_data SHALL hold its value until the next successful load; stores never modify it.
REQ-035 mem_en, done, err SHALL be 0 in IDLE; mem_ready outside ACCESS SHALL be ignored.

Reset
REQ-036 rst=1 at a clock edge SHALL force IDLE, counter 0, load_data 0, done 0, err 0, mem_en 0, mem_we 0, mem_be 0000, mem_addr 0, mem_wdata 0, from any state including mid-ACCESS.
REQ-037 Combinational stall SHALL follow REQ-025 from the post-reset state (IDLE).

Verification
REQ-038 LW addr 0x0000_0104, mem_ready after 2 ACCESS cycles, mem_rdata 0xDEAD_BEEF -> mem_be 1111, mem_addr 0x104, stall 3 cycles, done pulse, load_data 0xDEAD_BEEF.
REQ-039 LB addr 0x107, mem_rdata 0x80FF_1234 -> mem_be 1000, load_data 0xFFFF_FF80; LBU same -> 0x0000_0080; LHU addr 0x102 -> 0x0000_80FF.
REQ-040 SH addr 0x202, wdata 0x1234_ABCD -> mem_we 1, mem_be 1100, mem_wdata 0xABCD_ABCD, mem_addr 0x200, done pulse, load_data unchanged.
REQ-041 LW addr 0x101 or funct3 011 -> err pulse next cycle, mem_en never asserted, stall 1 cycle.
REQ-042 TIMEOUT=15, mem_ready held 0 -> exactly 15 ACCESS cycles with mem_en=1, then err pulse; mem_ready on cycle 15 instead -> done, no err.
REQ-043 rst asserted during ACCESS cycle 3 -> next cycle IDLE, mem_en 0, load_data 0, no done/err pulse.
